id_operand_scoreboard: RTL

//  Parametrised operand-resolution unit for the ID stage. It merges regfile read data with NSTG

---
 rtl/id_operand_scoreboard.sv | 116 +++++++++++
 1 files changed

// File: rtl/id_operand_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : id_operand_scoreboard
// Description : ID-stage operand resolution: priority forwarding merge for
//               NREAD read ports plus load-use hazard detection via a
//               LOAD_LAT-deep pending-load shift table.
// Revision    : 1.0  initial release
// ============================================================================
module id_operand_scoreboard #(
    parameter int NREAD    = 2,
    parameter int NSTG     = 3,
    parameter int LOAD_LAT = 2,
    parameter int DW       = 32,
    parameter int AW       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  hold_i,
    input  logic                  issue_valid_i,
    input  logic                  issue_is_load_i,
    input  logic [AW-1:0]         issue_waddr_i,
    input  logic [NREAD-1:0]      rd_en_i,
    input  logic [NREAD*AW-1:0]   raddr_i,
    input  logic [NREAD*DW-1:0]   rf_rdata_i,
    input  logic [NSTG-1:0]       fwd_we_i,
    input  logic [NSTG*AW-1:0]    fwd_waddr_i,
    input  logic [NSTG*DW-1:0]    fwd_wdata_i,
    output logic [NREAD*DW-1:0]   rdata_o,
    output logic                  stallreq_o,
    output logic [31:0]           stall_cnt_o
);

    logic [LOAD_LAT-1:0]         pend_v_q, pend_v_d;
    logic [LOAD_LAT-1:0][AW-1:0] pend_a_q, pend_a_d;
    logic [31:0]                 stall_cnt_q;
    logic                        w_stall;
    logic                        w_ins;

    // Per-port forwarding: lowest (youngest) matching stage wins, r0 forced to zero.
    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [AW-1:0] w_ra;
        logic [DW-1:0] w_res;

        assign w_ra = raddr_i[p*AW +: AW];

        always_comb begin
            w_res = rf_rdata_i[p*DW +: DW];
            for (int s = NSTG - 1; s >= 0; s--) begin
                if (fwd_we_i[s] && (fwd_waddr_i[s*AW +: AW] == w_ra)) begin
                    w_res = fwd_wdata_i[s*DW +: DW];
                end
            end
            if (w_ra == '0) begin
                w_res = '0;
            end
        end

        assign rdata_o[p*DW +: DW] = w_res;
    end

    always_comb begin
        w_stall = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            if (rd_en_i[p] && (raddr_i[p*AW +: AW] != '0)) begin
                for (int k = 0; k < LOAD_LAT; k++) begin
                    if (pend_v_q[k] && (pend_a_q[k] == raddr_i[p*AW +: AW])) begin
                        w_stall = 1'b1;
                    end
                end
            end
        end
    end

    // A stalled instruction is not really issued, so it must not enter the table.
    assign w_ins = issue_valid_i & issue_is_load_i & ~w_stall & (issue_waddr_i != '0);

    always_comb begin
        pend_v_d = pend_v_q;
        pend_a_d = pend_a_q;
        if (!hold_i) begin
            for (int k = LOAD_LAT - 1; k >= 1; k--) begin
                pend_v_d[k] = pend_v_q[k-1];
                pend_a_d[k] = pend_a_q[k-1];
            end
            pend_v_d[0] = w_ins;
            pend_a_d[0] = issue_waddr_i;
        end
        if (flush_i) begin
            pend_v_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q <= '0;
            pend_a_q <= '0;
        end else begin
            pend_v_q <= pend_v_d;
            pend_a_q <= pend_a_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stallreq_o  = w_stall;
    assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire
